// File: rtl/eth_rx_axis_packer.sv
// eth_rx_axis_packer: packs the MAC's 8-bit RX stream into OUT_BYTES-wide words,
// truncating frames longer than MAX_FRAME_LEN and keeping per-frame status counters.
`default_nettype none

module eth_rx_axis_packer #(
  parameter int OUT_BYTES     = 4,
  parameter int MAX_FRAME_LEN = 1522,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clock125,
  input  logic                   reset,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [8*OUT_BYTES-1:0] m_axis_tdata,
  output logic [OUT_BYTES-1:0]   m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic [COUNT_WIDTH-1:0] frame_len,
  output logic                   frame_len_valid,
  output logic [31:0]            frame_count,
  output logic [31:0]            bad_count
);

  localparam int LANE_W = $clog2(OUT_BYTES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_TRUNC  = 2'd2;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  // Length limit clamped to what the counter can represent.
  localparam logic [COUNT_WIDTH-1:0] MAX_LEN =
    (longint'(MAX_FRAME_LEN) > longint'(CNT_MAX)) ? CNT_MAX : COUNT_WIDTH'(MAX_FRAME_LEN);

  logic [1:0]             state_q, state_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [8*OUT_BYTES-1:0] asm_q, asm_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   dropped_q, dropped_d;
  logic [8*OUT_BYTES-1:0] m_data_q, m_data_d;
  logic [OUT_BYTES-1:0]   m_keep_q, m_keep_d;
  logic                   m_valid_q, m_valid_d;
  logic                   m_last_q, m_last_d;
  logic                   m_user_q, m_user_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic                   len_valid_q, len_valid_d;
  logic [31:0]            fcnt_q, fcnt_d;
  logic [31:0]            bcnt_q, bcnt_d;

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_store;
  logic                   w_drop;
  logic                   w_full;
  logic                   w_emit;
  logic                   w_bad;
  logic [LANE_W:0]        w_fill;
  logic [COUNT_WIDTH-1:0] w_cnt_next;
  logic [8*OUT_BYTES-1:0] w_word;
  logic [OUT_BYTES-1:0]   w_keep;

  assign w_ready    = !reset && (!m_valid_q || m_axis_tready);
  assign w_accept   = s_axis_tvalid && w_ready;
  assign w_store    = w_accept && s_axis_tkeep && (state_q != ST_TRUNC);
  assign w_drop     = w_accept && s_axis_tkeep && (state_q == ST_TRUNC);
  assign w_fill     = {1'b0, lane_q} + (LANE_W+1)'(w_store);
  assign w_full     = w_store && (lane_q == LANE_W'(OUT_BYTES-1));
  assign w_emit     = w_full || (w_accept && s_axis_tlast);
  assign w_bad      = s_axis_tuser || dropped_q || w_drop;
  assign w_cnt_next = (w_accept && s_axis_tkeep && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    w_word = asm_q;
    w_keep = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (w_store && (lane_q == LANE_W'(i))) begin
        w_word[8*i +: 8] = s_axis_tdata;
      end
      w_keep[i] = ((LANE_W+1)'(i) < w_fill);
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = w_store ? lane_q + 1'b1 : lane_q;
    asm_d       = w_word;
    cnt_d       = w_cnt_next;
    dropped_d   = dropped_q || w_drop;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_valid_d   = m_valid_q && !m_axis_tready;
    m_last_d    = m_last_q;
    m_user_d    = m_user_q;
    len_d       = len_q;
    len_valid_d = 1'b0;
    fcnt_d      = fcnt_q;
    bcnt_d      = bcnt_q;

    if (w_accept) begin
      case (state_q)
        ST_IDLE, ST_ACTIVE: state_d = (w_store && (w_cnt_next >= MAX_LEN)) ? ST_TRUNC : ST_ACTIVE;
        ST_TRUNC:           state_d = ST_TRUNC;
        default:            state_d = ST_IDLE;
      endcase
    end

    // Lanes are cleared on every emit so unfilled lanes of the next word read as zero.
    if (w_emit) begin
      m_data_d  = w_word;
      m_keep_d  = w_keep;
      m_last_d  = s_axis_tlast;
      m_user_d  = s_axis_tlast && w_bad;
      m_valid_d = 1'b1;
      asm_d     = '0;
      lane_d    = '0;
    end

    if (w_accept && s_axis_tlast) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      dropped_d   = 1'b0;
      len_d       = (w_cnt_next > MAX_LEN) ? MAX_LEN : w_cnt_next;
      len_valid_d = 1'b1;
      fcnt_d      = fcnt_q + 32'd1;
      if (w_bad) begin
        bcnt_d = bcnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock125) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      asm_q       <= '0;
      cnt_q       <= '0;
      dropped_q   <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_user_q    <= 1'b0;
      len_q       <= '0;
      len_valid_q <= 1'b0;
      fcnt_q      <= '0;
      bcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      dropped_q   <= dropped_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_user_q    <= m_user_d;
      len_q       <= len_d;
      len_valid_q <= len_valid_d;
      fcnt_q      <= fcnt_d;
      bcnt_q      <= bcnt_d;
    end
  end

  assign s_axis_tready   = w_ready;
  assign m_axis_tdata    = m_data_q;
  assign m_axis_tkeep    = m_keep_q;
  assign m_axis_tvalid   = m_valid_q;
  assign m_axis_tlast    = m_last_q;
  assign m_axis_tuser    = m_user_q;
  assign frame_len       = len_q;
  assign frame_len_valid = len_valid_q;
  assign frame_count     = fcnt_q;
  assign bad_count       = bcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_rx_axis_packer.sv
// Directed self-checking bench for eth_rx_axis_packer (OUT_BYTES=4, MAX_FRAME_LEN=1522).
`default_nettype none

module tb_eth_rx_axis_packer;

  logic        clock125 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tkeep = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [15:0] frame_len;
  logic        frame_len_valid;
  logic [31:0] frame_count;
  logic [31:0] bad_count;

  eth_rx_axis_packer #(
    .OUT_BYTES(4), .MAX_FRAME_LEN(1522), .COUNT_WIDTH(16)
  ) dut (
    .clock125(clock125), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .frame_len(frame_len), .frame_len_valid(frame_len_valid),
    .frame_count(frame_count), .bad_count(bad_count)
  );

  always #4 clock125 = ~clock125;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] q_data[$];
  logic [3:0]  q_keep[$];
  logic        q_last[$];
  logic        q_user[$];
  logic [7:0]  exp_q[$];
  int          tlast_seen = 0;
  int          stall_err = 0;
  int          last_len = -1;
  int          rdy_mode = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  logic        prev_last;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(posedge clock125) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = !m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Mid-cycle monitor: records every output handshake and checks stall stability.
  always @(negedge clock125) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata != prev_data ||
                         m_axis_tkeep != prev_keep || m_axis_tlast != prev_last))
        stall_err++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_keep  = m_axis_tkeep;
      prev_last  = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        q_data.push_back(m_axis_tdata);
        q_keep.push_back(m_axis_tkeep);
        q_last.push_back(m_axis_tlast);
        q_user.push_back(m_axis_tuser);
        if (m_axis_tlast) tlast_seen++;
      end
      if (frame_len_valid) last_len = int'(frame_len);
    end
  end

  task automatic clear_all();
    q_data.delete(); q_keep.delete(); q_last.delete(); q_user.delete();
    exp_q.delete();
    tlast_seen = 0;
    last_len = -1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [7:0] d, input logic k, input logic l, input logic u);
    int  cyc = 0;
    bit  acc = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
    s_axis_tvalid = 1'b1;
    while (!acc && cyc < 1000) begin
      @(negedge clock125);
      acc = s_axis_tready;
      @(posedge clock125);
      #1;
      cyc++;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    if (!acc) chk("beat_accept", longint'(acc), 1);
  endtask

  task automatic send_frame(input int n, input int base, input bit rnd,
                            input bit user, input bit last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      d = rnd ? 8'($urandom) : 8'(base + i);
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(posedge clock125);
        #1;
      end
      if (exp_q.size() < 1522) exp_q.push_back(d);
      send_beat(d, 1'b1, last && (i == n-1), user && (i == n-1));
    end
  endtask

  task automatic wait_done(input int n);
    int cyc = 0;
    while (tlast_seen < n && cyc < 5000) begin
      @(negedge clock125);
      cyc++;
    end
    chk("drain_tlast_words", tlast_seen, n);
    repeat (3) @(posedge clock125);
    #1;
  endtask

  task automatic check_stream(input string tag);
    logic [7:0] got[$];
    int errs = 0;
    foreach (q_data[w])
      for (int b = 0; b < 4; b++)
        if (q_keep[w][b]) got.push_back(q_data[w][8*b +: 8]);
    if (got.size() != exp_q.size()) errs += 1000;
    foreach (exp_q[i])
      if (i < got.size() && got[i] != exp_q[i]) errs++;
    chk(tag, errs, 0);
  endtask

  initial begin
    repeat (3) @(negedge clock125);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_bad_count", bad_count, 0);
    chk("rst_frame_len", frame_len, 0);
    @(posedge clock125); #1;
    reset = 1'b0;
    @(posedge clock125); #1;

    // 64-byte frame
    clear_all();
    send_frame(64, 0, 0, 0, 1, 0);
    wait_done(1);
    chk("t1_words", q_data.size(), 16);
    chk("t1_first_data", q_data[0], 32'h03020100);
    chk("t1_first_keep", q_keep[0], 4'hF);
    chk("t1_last_data", q_data[15], 32'h3F3E3D3C);
    chk("t1_last_tlast", q_last[15], 1);
    chk("t1_last_tuser", q_user[15], 0);
    chk("t1_frame_len", last_len, 64);
    chk("t1_frame_count", frame_count, 1);
    check_stream("t1_stream");

    // 61-byte frame: one residual byte
    clear_all();
    send_frame(61, 0, 0, 0, 1, 0);
    wait_done(1);
    chk("t2_words", q_data.size(), 16);
    chk("t2_last_keep", q_keep[15], 4'b0001);
    chk("t2_last_data", q_data[15], 32'h0000003C);
    chk("t2_last_tlast", q_last[15], 1);
    chk("t2_last_tuser", q_user[15], 0);
    chk("t2_frame_len", last_len, 61);

    // 1600-byte frame truncated at 1522
    clear_all();
    send_frame(1600, 0, 0, 0, 1, 0);
    wait_done(1);
    chk("t3_words", q_data.size(), 381);
    chk("t3_word379_keep", q_keep[379], 4'hF);
    chk("t3_word379_tlast", q_last[379], 0);
    chk("t3_last_keep", q_keep[380], 4'b0011);
    chk("t3_last_data", q_data[380], 32'h0000F1F0);
    chk("t3_last_tlast", q_last[380], 1);
    chk("t3_last_tuser", q_user[380], 1);
    chk("t3_frame_len", last_len, 1522);
    chk("t3_bad_count", bad_count, 1);
    chk("t3_frame_count", frame_count, 3);
    check_stream("t3_stream");

    // Backpressure toggling and input gaps with random data
    clear_all();
    stall_err = 0;
    rdy_mode = 1;
    send_frame(100, 0, 1, 0, 1, 1);
    wait_done(1);
    rdy_mode = 2;
    send_frame(37, 0, 1, 0, 1, 1);
    wait_done(2);
    rdy_mode = 0;
    @(posedge clock125); #1;
    check_stream("t4_stream");
    chk("t4_stall_stable", stall_err, 0);
    chk("t4_frame_len", last_len, 37);
    chk("t4_frame_count", frame_count, 5);

    // Bad frame from MAC, then a frame ending in a null tlast beat
    clear_all();
    send_frame(64, 0, 0, 1, 1, 0);
    wait_done(1);
    chk("t5_last_tuser", q_user[15], 1);
    chk("t5_first_tuser", q_user[0], 0);
    chk("t5_bad_count", bad_count, 2);
    clear_all();
    send_frame(8, 0, 0, 0, 0, 0);
    send_beat(8'hAA, 1'b0, 1'b1, 1'b0);
    wait_done(1);
    chk("t5n_words", q_data.size(), 3);
    chk("t5n_word1_data", q_data[1], 32'h07060504);
    chk("t5n_word1_tlast", q_last[1], 0);
    chk("t5n_null_keep", q_keep[2], 0);
    chk("t5n_null_data", q_data[2], 0);
    chk("t5n_null_tlast", q_last[2], 1);
    chk("t5n_null_tuser", q_user[2], 0);
    chk("t5n_frame_len", last_len, 8);
    chk("t5n_frame_count", frame_count, 7);
    chk("t5n_bad_count", bad_count, 2);

    // Reset mid-frame after 10 bytes
    clear_all();
    send_frame(10, 8'h80, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clock125);
    chk("t6_rst_s_tready", s_axis_tready, 0);
    @(negedge clock125);
    chk("t6_rst_m_tvalid", m_axis_tvalid, 0);
    chk("t6_rst_frame_count", frame_count, 0);
    @(posedge clock125); #1;
    reset = 1'b0;
    clear_all();
    @(posedge clock125); #1;
    send_frame(64, 0, 0, 0, 1, 0);
    wait_done(1);
    chk("t6_words", q_data.size(), 16);
    chk("t6_first_data", q_data[0], 32'h03020100);
    chk("t6_frame_count", frame_count, 1);
    chk("t6_frame_len", last_len, 64);
    check_stream("t6_stream");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
